// File: rtl/cache_line_xfer.sv
// Line-transfer engine: splits one refill/write-back line command into NWORDS word
// requests, gathers out-of-order responses, and returns the completed line.
// Optional critical-word-first issue order: define CACHE_LINE_XFER_CRIT_WORD_FIRST_EN.
module cache_line_xfer #(
  parameter int NWORDS = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int OW     = $clog2(NWORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_val,
  output logic                 cmd_rdy,
  input  logic                 cmd_rw,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [NWORDS*DW-1:0] cmd_wdata,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  output logic                 memreq_type,
  output logic [AW-1:0]        memreq_addr,
  output logic [DW-1:0]        memreq_data,
  output logic [OW-1:0]        memreq_opaque,
  input  logic                 memresp_val,
  output logic                 memresp_rdy,
  input  logic [OW-1:0]        memresp_opaque,
  input  logic [DW-1:0]        memresp_data,
  output logic                 line_val,
  input  logic                 line_rdy,
  output logic                 line_rw,
  output logic [NWORDS*DW-1:0] line_data
);
  localparam int LW = NWORDS * DW;
  localparam int CW = $clog2(NWORDS) + 1;
  localparam int BB = $clog2(DW / 8);
  localparam logic [AW-1:0] ALIGN = ~(AW'(NWORDS * DW / 8 - 1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [LW-1:0]     line_q, line_d;
  logic [CW-1:0]     req_cnt_q, req_cnt_d;
  logic [CW-1:0]     resp_cnt_q, resp_cnt_d;
  logic [NWORDS-1:0] mask_q, mask_d;
  logic [OW-1:0]     start_q, start_d;
  logic [OW-1:0]     idx;
  logic              req_fire, resp_fire, resp_ok;

  assign idx         = start_q + req_cnt_q[OW-1:0];
  assign cmd_rdy     = (state_q == S_IDLE);
  assign memresp_rdy = (state_q == S_BUSY);
  assign line_val    = (state_q == S_DONE);
  assign line_rw     = rw_q;
  assign line_data   = line_q;

  // Request fields are built from registered state only and idle at zero.
  assign memreq_val    = (state_q == S_BUSY) && (req_cnt_q < CW'(NWORDS));
  assign memreq_type   = rw_q;
  assign memreq_opaque = memreq_val ? idx : '0;
  assign memreq_addr   = memreq_val ? (addr_q | (AW'(idx) << BB)) : '0;
  assign memreq_data   = (memreq_val && rw_q) ? line_q[idx*DW +: DW] : '0;

  assign req_fire  = memreq_val && memreq_rdy;
  assign resp_fire = memresp_val && memresp_rdy;
  // Duplicate or unrequested responses are swallowed without being counted.
  assign resp_ok   = resp_fire && !mask_q[memresp_opaque] && (req_cnt_q > resp_cnt_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    line_d     = line_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    mask_d     = mask_q;
    start_d    = start_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_val) begin
          addr_d     = cmd_addr & ALIGN;
          rw_d       = cmd_rw;
          line_d     = cmd_rw ? cmd_wdata : '0;
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          mask_d     = '0;
`ifdef CACHE_LINE_XFER_CRIT_WORD_FIRST_EN
          start_d    = cmd_addr[BB +: OW];
`else
          start_d    = '0;
`endif
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (req_fire) req_cnt_d = req_cnt_q + 1'b1;
        if (resp_ok) begin
          resp_cnt_d             = resp_cnt_q + 1'b1;
          mask_d[memresp_opaque] = 1'b1;
          if (!rw_q) line_d[memresp_opaque*DW +: DW] = memresp_data;
        end
        if (resp_cnt_d == CW'(NWORDS)) state_d = S_DONE;
      end
      S_DONE: begin
        if (line_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      line_q     <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      mask_q     <= '0;
      start_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      line_q     <= line_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      mask_q     <= mask_d;
      start_q    <= start_d;
    end
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Randomized bench for cache_line_xfer with a transaction-level memory/line model.
module tb_cache_line_xfer;
  localparam int NWORDS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int LW = NWORDS * DW;
`ifdef CACHE_LINE_XFER_CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_val, cmd_rdy, cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_wdata;
  logic          memreq_val, memreq_rdy, memreq_type;
  logic [AW-1:0] memreq_addr;
  logic [DW-1:0] memreq_data;
  logic [OW-1:0] memreq_opaque;
  logic          memresp_val, memresp_rdy;
  logic [OW-1:0] memresp_opaque;
  logic [DW-1:0] memresp_data;
  logic          line_val, line_rdy, line_rw;
  logic [LW-1:0] line_data;

  int n_cmp = 0;
  int n_bad = 0;

  cache_line_xfer #(.NWORDS(NWORDS), .AW(AW), .DW(DW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_data(memreq_data), .memreq_opaque(memreq_opaque),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_opaque(memresp_opaque), .memresp_data(memresp_data),
    .line_val(line_val), .line_rdy(line_rdy), .line_rw(line_rw), .line_data(line_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_req_val", memreq_val, 0);
    chk("rst_resp_rdy", memresp_rdy, 0);
    chk("rst_line_val", line_val, 0);
    chk("rst_req_addr", memreq_addr, 0);
    chk("rst_req_data", memreq_data, 0);
    chk("rst_req_op", memreq_opaque, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_line_rw", line_rw, 0);
  endtask

  // mode 0: memory answers the oldest request next cycle; 1: random order/delays;
  // 2: hold all responses until every request issued, then answer in perm order.
  task automatic run_xfer(input logic rw, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata,
                          input int mode, input int stall_at, input int lstall,
                          input logic [NWORDS*OW-1:0] perm);
    int start, nreq, nresp, cyc, stall_left, lleft, k, eop;
    logic [OW-1:0] pend[$];
    logic [OW-1:0] o;
    logic [AW-1:0] base;
    logic [LW-1:0] exp_line;
    bit done, seen_line, fire_req;
    base       = addr & ~(AW'(NWORDS * DW / 8 - 1));
    start      = CRIT ? int'((addr >> 2) % NWORDS) : 0;
    exp_line   = rw ? wdata : rdata;
    nreq       = 0;
    nresp      = 0;
    stall_left = (stall_at >= 0) ? 3 : 0;
    lleft      = lstall;
    done       = 1'b0;
    seen_line  = 1'b0;
    pend.delete();

    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_val = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_val = 1'b0; cmd_addr = $urandom; cmd_wdata = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (!done && cyc < 200) begin
      chk("cmd_rdy_busy", cmd_rdy, 0);
      chk("req_val", memreq_val, nreq < NWORDS);
      chk("resp_rdy", memresp_rdy, nresp < NWORDS);
      chk("line_val", line_val, nresp == NWORDS);
      if (memreq_val) begin
        eop = (start + nreq) % NWORDS;
        chk("req_op", memreq_opaque, eop);
        chk("req_addr", memreq_addr, base + AW'(4 * eop));
        chk("req_type", memreq_type, rw);
        chk("req_data", memreq_data, rw ? wdata[eop*DW +: DW] : '0);
      end
      memreq_rdy = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
      if (stall_at >= 0 && nreq == stall_at && stall_left > 0) begin
        memreq_rdy = 1'b0;
        stall_left--;
      end
      fire_req = memreq_val && memreq_rdy;

      memresp_val = 1'b0; memresp_opaque = OW'($urandom); memresp_data = $urandom;
      if (nresp < NWORDS) begin
        if (mode == 0 && pend.size() > 0) begin
          o = pend.pop_front();
          memresp_val = 1'b1;
        end else if (mode == 1 && pend.size() > 0 && $urandom % 3 != 0) begin
          k = $urandom % pend.size();
          o = pend[k];
          pend.delete(k);
          memresp_val = 1'b1;
        end else if (mode == 2 && nreq == NWORDS) begin
          o = perm[nresp*OW +: OW];
          memresp_val = 1'b1;
        end
        if (memresp_val) begin
          memresp_opaque = o;
          memresp_data   = rw ? DW'($urandom) : rdata[o*DW +: DW];
          nresp++;
        end
      end
      if (fire_req) begin
        pend.push_back(OW'((start + nreq) % NWORDS));
        nreq++;
      end

      line_rdy = 1'b0;
      if (line_val) begin
        if (!seen_line && mode == 0 && stall_at < 0) chk("latency", cyc, NWORDS + 2);
        seen_line = 1'b1;
        chk("line_data", line_data, exp_line);
        chk("line_rw", line_rw, rw);
        if (lleft > 0) lleft--;
        else begin
          line_rdy = 1'b1;
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    line_rdy = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0;
    chk("line_val_drop", line_val, 0);
    chk("cmd_rdy_after", cmd_rdy, 1);
  endtask

  logic [LW-1:0] rd, wd;
  logic rrw;
  int sat;

  initial begin
    reset = 1'b0;
    cmd_val = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_opaque = '0; memresp_data = '0;
    line_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    reset = 1'b1;
    @(posedge clk); #1;

    rd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_xfer(1'b0, 32'h0000_1234, '0, rd, 0, -1, 0, '0);
    run_xfer(1'b1, 32'h40, {32'd4, 32'd3, 32'd2, 32'd1}, '0, 0, -1, 0, '0);
    run_xfer(1'b0, 32'h2000, '0, {$urandom, $urandom, $urandom, $urandom}, 2, -1, 0,
             {2'd1, 2'd2, 2'd0, 2'd3});
    run_xfer(1'b0, 32'h3010, '0, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 2, '0);

    // Abandon a write-back after two requests with an asynchronous reset pulse.
    cmd_val = 1'b1; cmd_rw = 1'b1; cmd_addr = 32'h80;
    cmd_wdata = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    @(posedge clk); #1;
    cmd_val = 1'b0; memreq_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs();
    memreq_rdy = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_req_val", memreq_val, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_val", memreq_val, 0);
    run_xfer(1'b0, 32'h5550, '0, {$urandom, $urandom, $urandom, $urandom}, 1, -1, 0, '0);

    run_xfer(1'b0, 32'h0000_1238, '0, rd, 0, -1, 0, '0);

    for (int t = 0; t < 24; t++) begin
      rrw = 1'(($urandom % 2));
      wd  = {$urandom, $urandom, $urandom, $urandom};
      rd  = {$urandom, $urandom, $urandom, $urandom};
      sat = ($urandom % 2 == 0) ? int'($urandom % NWORDS) : -1;
      run_xfer(rrw, $urandom, wd, rd, 1, sat, int'($urandom % 3), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
